sha_core_arbiter: RTL and testbench

Shares one sha_algo core between NUM_REQ independent requesters, each presenting a pre-padded 512-bit block. Arbitration is round-robin. Only one block is in the core at a time; the 256-bit digest is returned to the requester that submitted the block. The block sits between the requester-side logic and sha_algo, and drives that core's message and hash handshakes.

---
 rtl/sha_core_arbiter.sv | 140 ++++++++++++++
 tb/tb_sha_core_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_core_arbiter.sv
// Round-robin arbiter sharing one sha_algo core between NUM_REQ requesters.
// One block in flight at a time; the digest is returned to the requester that submitted it.
module sha_core_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_p,
  input  logic                   reset_p,
  input  logic [NUM_REQ-1:0]     req_valid_p,
  output logic [NUM_REQ-1:0]     req_ready_p,
  input  logic [NUM_REQ*512-1:0] req_message_p,
  output logic [NUM_REQ-1:0]     resp_valid_p,
  input  logic [NUM_REQ-1:0]     resp_ready_p,
  output logic [255:0]           resp_hash_p,
  output logic                   resp_err_p,
  output logic [IDX_W-1:0]       grant_idx_p,
  output logic                   busy_p,
  output logic [511:0]           core_message_p,
  output logic                   core_message_valid_p,
  input  logic                   core_message_ready_p,
  input  logic [255:0]           core_hash_p,
  input  logic                   core_hash_valid_p,
  output logic                   core_hash_ready_p
);

  localparam int CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast =
      CntW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitHash, StResp} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] grant_q;
  logic [511:0]     msg_q;
  logic [255:0]     hash_q;
  logic             err_q;
  logic [CntW-1:0]  cnt_q;

  logic [IDX_W-1:0] hi_idx, lo_idx, win;
  logic             hi_found, lo_found;
  logic [511:0]     win_msg;
  logic             resp_ack;
  logic             timeout_hit;

  // Lowest valid index at or above rr_q wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_p[i]) begin
        lo_idx   = IDX_W'(i);
        lo_found = 1'b1;
        if (IDX_W'(i) >= rr_q) begin
          hi_idx   = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    win = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    win_msg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IDX_W'(i)) win_msg = req_message_p[512*i +: 512];
    end
  end

  always_comb begin
    req_ready_p  = '0;
    resp_valid_p = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state_q == StIdle && lo_found && !reset_p && win == IDX_W'(i)) req_ready_p[i] = 1'b1;
      if (state_q == StResp && grant_q == IDX_W'(i)) resp_valid_p[i] = 1'b1;
    end
  end

  assign resp_ack    = (state_q == StResp) && ((resp_ready_p & resp_valid_p) != '0);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

  always_ff @(posedge clk_p) begin
    if (reset_p) begin
      state_q <= StIdle;
      rr_q    <= '0;
      grant_q <= '0;
      msg_q   <= '0;
      hash_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (lo_found) begin
            msg_q   <= win_msg;
            grant_q <= win;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (core_message_ready_p) state_q <= StWaitHash;
        end
        StWaitHash: begin
          cnt_q <= cnt_q + 1'b1;
          // A digest arriving in the timeout cycle still takes precedence.
          if (core_hash_valid_p) begin
            hash_q  <= core_hash_p;
            err_q   <= 1'b0;
            state_q <= StResp;
          end else if (timeout_hit) begin
            hash_q  <= '0;
            err_q   <= 1'b1;
            state_q <= StResp;
          end
        end
        StResp: begin
          if (resp_ack) begin
            rr_q    <= (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
            cnt_q   <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign core_message_p       = msg_q;
  assign core_message_valid_p = (state_q == StIssue);
  assign core_hash_ready_p    = (state_q == StWaitHash);
  assign busy_p               = (state_q != StIdle);
  assign grant_idx_p          = grant_q;
  assign resp_hash_p          = hash_q;
  assign resp_err_p           = err_q;

endmodule

// File: tb/tb_sha_core_arbiter.sv
// Directed bench for sha_core_arbiter with a small stub standing in for sha_algo.
module tb_sha_core_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 16;

  localparam logic [511:0] AbcdBlk = {32'h00000020, 416'h0, 32'h80000000, 32'h61626364};
  localparam logic [255:0] AbcdDig =
      256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [N*512-1:0] req_message;
  logic [255:0]   resp_hash, core_hash;
  logic           resp_err, busy;
  logic [IW-1:0]  grant_idx;
  logic [511:0]   core_message;
  logic           core_message_valid, core_message_ready, core_hash_valid, core_hash_ready;

  logic [511:0]   blk [N];
  logic           msg_rdy_en, core_hang;
  logic           stub_busy, stub_hang;
  logic [1:0]     stub_cnt;
  logic [511:0]   stub_msg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign req_message        = {blk[3], blk[2], blk[1], blk[0]};
  assign core_message_ready = msg_rdy_en;

  sha_core_arbiter #(.NUM_REQ(N), .IDX_W(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_p               (clk),
    .reset_p             (reset),
    .req_valid_p         (req_valid),
    .req_ready_p         (req_ready),
    .req_message_p       (req_message),
    .resp_valid_p        (resp_valid),
    .resp_ready_p        (resp_ready),
    .resp_hash_p         (resp_hash),
    .resp_err_p          (resp_err),
    .grant_idx_p         (grant_idx),
    .busy_p              (busy),
    .core_message_p      (core_message),
    .core_message_valid_p(core_message_valid),
    .core_message_ready_p(core_message_ready),
    .core_hash_p         (core_hash),
    .core_hash_valid_p   (core_hash_valid),
    .core_hash_ready_p   (core_hash_ready)
  );

  function automatic logic [255:0] model_hash(input logic [511:0] m);
    if (m == AbcdBlk) return AbcdDig;
    return m[511:256] ^ {m[247:0], m[255:248]};
  endfunction

  function automatic logic [511:0] pat(input int i);
    logic [31:0] w;
    w = 32'h01020304 + 32'(i) * 32'h10101010;
    return {16{w}};
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // Stub core: digest three cycles after accepting a block, or never when hung.
  always @(posedge clk) begin
    if (reset) begin
      stub_busy       <= 1'b0;
      stub_hang       <= 1'b0;
      stub_cnt        <= '0;
      stub_msg        <= '0;
      core_hash_valid <= 1'b0;
      core_hash       <= '0;
    end else begin
      if (core_hash_valid && core_hash_ready) begin
        core_hash_valid <= 1'b0;
        stub_busy       <= 1'b0;
      end else if (stub_busy && !core_hash_valid && !stub_hang) begin
        if (stub_cnt == 0) begin
          core_hash_valid <= 1'b1;
          core_hash       <= model_hash(stub_msg);
        end else begin
          stub_cnt <= stub_cnt - 1'b1;
        end
      end
      if (core_message_valid && core_message_ready) begin
        stub_busy       <= 1'b1;
        stub_msg        <= core_message;
        stub_cnt        <= 2'd2;
        stub_hang       <= core_hang;
        core_hash_valid <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_req: got no req_ready pulse expected one within 40 cycles");
    end
  endtask

  task automatic wait_resp(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int k = 0; k < 60; k++) begin
      if (resp_valid != '0) begin
        ok = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_resp: got no resp_valid expected one within 60 cycles");
    end
  endtask

  typedef struct {
    logic [N-1:0] mask;
    int           exp_g;
    bit           hang;
    int           stall;
    int           delay;
  } vec_t;

  task automatic run_vec(input vec_t v);
    bit           ok;
    int           cyc;
    logic [511:0] saved;
    logic [255:0] exp_hash;
    core_hang = v.hang;
    req_valid = v.mask;
    wait_req(ok);
    if (!ok) return;
    check("req_ready", req_ready, onehot(v.exp_g));
    check("busy_idle", busy, 0);
    tick();
    // Requester withdraws and scribbles over its block; the latched copy must survive.
    req_valid[v.exp_g] = 1'b0;
    saved = blk[v.exp_g];
    blk[v.exp_g] = ~saved;
    msg_rdy_en = (v.stall == 0);
    #1;
    check("issue_valid", core_message_valid, 1);
    check("core_msg", core_message, saved);
    check("grant_idx", grant_idx, v.exp_g);
    check("req_ready_busy", req_ready, 0);
    check("hash_ready_issue", core_hash_ready, 0);
    for (int s = 1; s <= v.stall; s++) begin
      tick();
      check("issue_hold", core_message_valid, 1);
      if (s == v.stall) msg_rdy_en = 1'b1;
    end
    tick();
    check("wait_hash_ready", core_hash_ready, 1);
    check("wait_msg_valid", core_message_valid, 0);
    wait_resp(cyc, ok);
    if (!ok) return;
    if (v.hang) check("timeout_cycles", cyc, TO);
    exp_hash = v.hang ? '0 : model_hash(saved);
    check("resp_valid", resp_valid, onehot(v.exp_g));
    check("resp_hash", resp_hash, exp_hash);
    check("resp_err", resp_err, v.hang);
    resp_ready = ~onehot(v.exp_g);
    for (int d = 0; d < v.delay; d++) begin
      tick();
      check("hold_resp_valid", resp_valid, onehot(v.exp_g));
      check("hold_resp_hash", resp_hash, exp_hash);
      check("hold_req_ready", req_ready, 0);
      check("hold_msg_valid", core_message_valid, 0);
    end
    resp_ready = onehot(v.exp_g);
    tick();
    resp_ready = '0;
    req_valid  = '0;
    blk[v.exp_g] = saved;
    check("resp_done", resp_valid, 0);
    check("busy_done", busy, 0);
    check("hash_kept", resp_hash, exp_hash);
    check("err_kept", resp_err, v.hang);
  endtask

  vec_t vecs[7];

  initial begin
    bit ok;
    int cyc;
    vec_t t1;
    vecs[0] = '{4'b0100, 2, 1'b0, 1, 0};
    vecs[1] = '{4'b1010, 3, 1'b0, 0, 0};
    vecs[2] = '{4'b0010, 1, 1'b0, 2, 0};
    vecs[3] = '{4'b0001, 0, 1'b1, 0, 0};
    vecs[4] = '{4'b1001, 3, 1'b0, 0, 20};
    vecs[5] = '{4'b1111, 0, 1'b0, 0, 1};
    vecs[6] = '{4'b0011, 1, 1'b0, 0, 0};
    for (int i = 0; i < N; i++) blk[i] = pat(i);
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    msg_rdy_en = 1'b1;
    core_hang  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_grant", grant_idx, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_hash", resp_hash, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_core_msg", core_message, 0);
    check("rst_core_valid", core_message_valid, 0);
    check("rst_hash_ready", core_hash_ready, 0);

    // Single "abcd" block from requester 0.
    blk[0] = AbcdBlk;
    t1 = '{4'b0001, 0, 1'b0, 0, 0};
    run_vec(t1);
    check("abcd_digest", resp_hash, AbcdDig);
    blk[0] = pat(0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset during WAIT_HASH with rr_ptr at 2: the dropped block must not respond.
    req_valid = 4'b0100;
    wait_req(ok);
    check("pre_rst_grant", req_ready, onehot(2));
    tick();
    tick();
    check("pre_rst_wait", core_hash_ready, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant", grant_idx, 0);
    check("mid_rst_core_valid", core_message_valid, 0);
    check("mid_rst_hash_ready", core_hash_ready, 0);
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_resp_hash", resp_hash, 0);
    check("mid_rst_core_msg", core_message, 0);
    req_valid = 4'b0110;
    #1;
    check("mid_rst_rr", req_ready, onehot(1));
    t1 = '{4'b0110, 1, 1'b0, 0, 0};
    run_vec(t1);

    // Fresh reset, then all four requesters valid continuously.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_req(ok);
      check("rr_grant", req_ready, onehot(n % N));
      tick();
      check("rr_grant_idx", grant_idx, n % N);
      wait_resp(cyc, ok);
      check("rr_resp_valid", resp_valid, onehot(n % N));
      check("rr_resp_hash", resp_hash, model_hash(pat(n % N)));
      resp_ready = onehot(n % N);
      tick();
      resp_ready = '0;
    end
    req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
